// File: rtl/mips_pkg.sv
// Shared constants and encodings for the MIPS pipeline slice around ID/EX.
package mips_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALUOP_W = 3;

  // alu_unit operation codes: bit2 inverts B / subtracts, bits[1:0] select the function.
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // Operand source chosen by a forwarding mux.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXM = 2'd1,
    FWD_MWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Bypass selector for one EX operand: EX/MEM beats MEM/WB, and $0 is never bypassed.
module fwd_mux #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned REG_AW = mips_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] src_reg,
  input  logic [DATA_W-1:0] reg_val,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [DATA_W-1:0] mwb_result,
  output logic [DATA_W-1:0] value
);
  import mips_pkg::*;

  fwd_sel_e sel;

  // Pick the youngest in-flight producer of src_reg.
  always_comb begin
    sel = FWD_REG;
    if (src_reg != '0) begin
      if (exm_reg_write && (exm_rd == src_reg)) begin
        sel = FWD_EXM;
      end else if (mwb_reg_write && (mwb_rd == src_reg)) begin
        sel = FWD_MWB;
      end
    end
  end

  // Steer the selected source onto the operand.
  always_comb begin
    case (sel)
      FWD_EXM: value = exm_result;
      FWD_MWB: value = mwb_result;
      default: value = reg_val;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
module id_ex_stage #(
  parameter int unsigned DATA_W  = mips_pkg::DATA_W,
  parameter int unsigned REG_AW  = mips_pkg::REG_AW,
  parameter int unsigned ALUOP_W = mips_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [DATA_W-1:0]  id_rs_val,
  input  logic [DATA_W-1:0]  id_rt_val,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_alu_src,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               stall,
  input  logic               flush,
  input  logic               exm_reg_write,
  input  logic [REG_AW-1:0]  exm_rd,
  input  logic [DATA_W-1:0]  exm_result,
  input  logic               mwb_reg_write,
  input  logic [REG_AW-1:0]  mwb_rd,
  input  logic [DATA_W-1:0]  mwb_result,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               load_use_stall
);
  import mips_pkg::*;

  logic               valid_q;
  logic               reg_write_q;
  logic               mem_read_q;
  logic               alu_src_q;
  logic [ALUOP_W-1:0] alu_op_q;
  logic [REG_AW-1:0]  rs_q;
  logic [REG_AW-1:0]  rt_q;
  logic [REG_AW-1:0]  rd_q;
  logic [DATA_W-1:0]  rs_val_q;
  logic [DATA_W-1:0]  rt_val_q;
  logic [DATA_W-1:0]  imm_q;
  logic [DATA_W-1:0]  fwd_rs;
  logic [DATA_W-1:0]  fwd_rt;

  // A load in EX whose destination feeds the instruction in ID cannot be bypassed in time.
  always_comb begin
    load_use_stall = valid_q && mem_read_q && (rd_q != '0) && id_valid &&
                     ((rd_q == id_rs) || (rd_q == id_rt));
  end

  // Pipeline register: flush > stall > load-use bubble > capture.
  // Bubbles only clear control; datapath fields keep stale contents since they are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      alu_src_q   <= 1'b0;
      alu_op_q    <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      imm_q       <= '0;
    end else if (flush || (!stall && load_use_stall)) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      alu_op_q    <= ALUOP_W'(ALU_ADD);
    end else if (!stall) begin
      valid_q     <= id_valid;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
      alu_src_q   <= id_alu_src;
      alu_op_q    <= id_alu_op;
      rs_q        <= id_rs;
      rt_q        <= id_rt;
      rd_q        <= id_rd;
      rs_val_q    <= id_rs_val;
      rt_val_q    <= id_rt_val;
      imm_q       <= id_imm;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src_reg       (rs_q),
    .reg_val       (rs_val_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .value         (fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src_reg       (rt_q),
    .reg_val       (rt_val_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd        (exm_rd),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd        (mwb_rd),
    .mwb_result    (mwb_result),
    .value         (fwd_rt)
  );

  // Operand and control outputs toward alu_unit and MEM.
  always_comb begin
    ex_valid      = valid_q;
    ex_reg_write  = valid_q && reg_write_q;
    ex_mem_read   = valid_q && mem_read_q;
    ex_rd         = rd_q;
    alu_op        = alu_op_q;
    alu_a         = fwd_rs;
    alu_b         = alu_src_q ? imm_q : fwd_rt;
    ex_store_data = fwd_rt;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios followed by random traffic.
module tb_id_ex_stage;

  typedef struct packed {
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic [31:0] id_imm;
    logic        id_alu_src;
    logic [2:0]  id_alu_op;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        stall;
    logic        flush;
    logic        exm_reg_write;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        mwb_reg_write;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_result;
  } stim_t;

  // Reference view of the instruction sitting in EX.
  typedef struct {
    bit        valid;
    bit        reg_write;
    bit        mem_read;
    bit        alu_src;
    bit [2:0]  op;
    bit [4:0]  rs;
    bit [4:0]  rt;
    bit [4:0]  rd;
    bit [31:0] rs_val;
    bit [31:0] rt_val;
    bit [31:0] imm;
    bit        dp_known;
  } ex_model_t;

  typedef struct {
    bit        valid;
    bit        reg_write;
    bit        mem_read;
    bit [2:0]  op;
    bit        luse;
    bit        chk_dp;
    bit [31:0] a;
    bit [31:0] b;
    bit [31:0] sd;
    bit [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  stim_t       drv = '0;

  logic        ex_valid;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        load_use_stall;

  int checks = 0;
  int errors = 0;
  ex_model_t m;
  exp_t      q[$];

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .ALUOP_W(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (drv.id_valid),
    .id_rs          (drv.id_rs),
    .id_rt          (drv.id_rt),
    .id_rd          (drv.id_rd),
    .id_rs_val      (drv.id_rs_val),
    .id_rt_val      (drv.id_rt_val),
    .id_imm         (drv.id_imm),
    .id_alu_src     (drv.id_alu_src),
    .id_alu_op      (drv.id_alu_op),
    .id_reg_write   (drv.id_reg_write),
    .id_mem_read    (drv.id_mem_read),
    .stall          (drv.stall),
    .flush          (drv.flush),
    .exm_reg_write  (drv.exm_reg_write),
    .exm_rd         (drv.exm_rd),
    .exm_result     (drv.exm_result),
    .mwb_reg_write  (drv.mwb_reg_write),
    .mwb_rd         (drv.mwb_rd),
    .mwb_result     (drv.mwb_result),
    .ex_valid       (ex_valid),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_op         (alu_op),
    .ex_store_data  (ex_store_data),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .load_use_stall (load_use_stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Value an operand register reads in EX, given whatever is currently in flight downstream.
  function automatic bit [31:0] bypass(input bit [4:0] r, input bit [31:0] v, input stim_t s);
    if (r == 0) return v;
    if (s.exm_reg_write && s.exm_rd == r) return s.exm_result;
    if (s.mwb_reg_write && s.mwb_rd == r) return s.mwb_result;
    return v;
  endfunction

  function automatic bit hazard(input ex_model_t x, input stim_t s);
    return x.valid && x.mem_read && x.rd != 0 && s.id_valid &&
           (x.rd == s.id_rs || x.rd == s.id_rt);
  endfunction

  // Advance the EX model across one rising edge using the inputs held during the last cycle.
  task automatic model_edge();
    if (!rst_n) begin
      m = '{default: 0};
      m.dp_known = 1;
    end else if (drv.flush || (!drv.stall && hazard(m, drv))) begin
      m.valid = 0; m.reg_write = 0; m.mem_read = 0; m.op = 3'b010; m.dp_known = 0;
    end else if (!drv.stall) begin
      m.valid = drv.id_valid;     m.reg_write = drv.id_reg_write; m.mem_read = drv.id_mem_read;
      m.alu_src = drv.id_alu_src; m.op = drv.id_alu_op;
      m.rs = drv.id_rs; m.rt = drv.id_rt; m.rd = drv.id_rd;
      m.rs_val = drv.id_rs_val; m.rt_val = drv.id_rt_val; m.imm = drv.id_imm;
      m.dp_known = 1;
    end
  endtask

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    e.valid     = m.valid;
    e.reg_write = m.valid && m.reg_write;
    e.mem_read  = m.valid && m.mem_read;
    e.op        = m.op;
    e.luse      = hazard(m, s);
    e.chk_dp    = m.dp_known;
    e.a         = bypass(m.rs, m.rs_val, s);
    e.sd        = bypass(m.rt, m.rt_val, s);
    e.b         = m.alu_src ? m.imm : e.sd;
    e.rd        = m.rd;
    return e;
  endfunction

  // One clock: let the edge happen, update the model, present new inputs, queue the expectation.
  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    model_edge();
    drv = s;
    q.push_back(predict(s));
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s.id_valid      = ($urandom_range(0, 3) != 0);
    s.id_rs         = 5'($urandom_range(0, 7));
    s.id_rt         = 5'($urandom_range(0, 7));
    s.id_rd         = 5'($urandom_range(0, 7));
    s.id_rs_val     = $urandom;
    s.id_rt_val     = $urandom;
    s.id_imm        = $urandom;
    s.id_alu_src    = 1'($urandom_range(0, 1));
    s.id_alu_op     = 3'($urandom_range(0, 7));
    s.id_reg_write  = 1'($urandom_range(0, 1));
    s.id_mem_read   = ($urandom_range(0, 2) == 0);
    s.stall         = ($urandom_range(0, 5) == 0);
    s.flush         = ($urandom_range(0, 9) == 0);
    s.exm_reg_write = 1'($urandom_range(0, 1));
    s.exm_rd        = 5'($urandom_range(0, 7));
    s.exm_result    = $urandom;
    s.mwb_reg_write = 1'($urandom_range(0, 1));
    s.mwb_rd        = 5'($urandom_range(0, 7));
    s.mwb_result    = $urandom;
    return s;
  endfunction

  // Monitor: every cycle the DUT presents a settled output set, compare it with the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ex_valid", ex_valid, e.valid);
      chk("ex_reg_write", ex_reg_write, e.reg_write);
      chk("ex_mem_read", ex_mem_read, e.mem_read);
      chk("alu_op", alu_op, e.op);
      chk("load_use_stall", load_use_stall, e.luse);
      if (e.chk_dp) begin
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("ex_store_data", ex_store_data, e.sd);
        chk("ex_rd", ex_rd, e.rd);
      end
    end
  end

  initial begin
    stim_t idle;
    stim_t s;
    stim_t t;
    idle = '0;

    // Power-on reset, then release with nothing valid in ID.
    step(idle);
    step(idle);
    @(negedge clk);
    rst_n = 1'b1;
    step(idle);
    step(idle);
    @(negedge clk); #1;
    chk("post_reset_valid", ex_valid, 1'b0);

    // Plain capture with no bypass matches.
    s = idle;
    s.id_valid = 1; s.id_rs = 1; s.id_rt = 2; s.id_rd = 3;
    s.id_rs_val = 5; s.id_rt_val = 7; s.id_alu_op = 3'b010; s.id_reg_write = 1;
    step(s);
    step(idle);
    @(negedge clk); #1;
    chk("cap_a", alu_a, 32'd5);
    chk("cap_b", alu_b, 32'd7);
    chk("cap_op", alu_op, 3'b010);
    chk("cap_valid", ex_valid, 1'b1);

    // Asynchronous reset asserted between edges clears outputs at once.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ex_valid, 1'b0);
    chk("async_rst_a", alu_a, 32'd0);
    chk("async_rst_b", alu_b, 32'd0);
    chk("async_rst_op", alu_op, 3'd0);
    chk("async_rst_rw", ex_reg_write, 1'b0);
    step(idle);
    @(negedge clk);
    rst_n = 1'b1;

    // Forwarding priority on rs: EX/MEM beats MEM/WB; without EX/MEM, MEM/WB wins.
    s = idle;
    s.id_valid = 1; s.id_rs = 3; s.id_rt = 9; s.id_rd = 10; s.id_rs_val = 32'h11; s.id_alu_op = 3'b010;
    step(s);
    t = idle;
    t.stall = 1;
    t.exm_reg_write = 1; t.exm_rd = 3; t.exm_result = 32'hAA;
    t.mwb_reg_write = 1; t.mwb_rd = 3; t.mwb_result = 32'hBB;
    step(t);
    @(negedge clk); #1;
    chk("fwd_exm_a", alu_a, 32'hAA);
    t.exm_reg_write = 0;
    step(t);
    @(negedge clk); #1;
    chk("fwd_mwb_a", alu_a, 32'hBB);

    // Register $0 is never bypassed.
    s = idle;
    s.id_valid = 1; s.id_rs = 0; s.id_rs_val = 0; s.id_alu_op = 3'b001;
    step(s);
    t = idle;
    t.stall = 1;
    t.exm_reg_write = 1; t.exm_rd = 0; t.exm_result = 32'hFF;
    t.mwb_reg_write = 1; t.mwb_rd = 0; t.mwb_result = 32'hEE;
    step(t);
    @(negedge clk); #1;
    chk("zero_guard_a", alu_a, 32'd0);

    // Load-use: lw r4 then add using r4 -> stall, bubble, re-presented add captured.
    s = idle;
    s.id_valid = 1; s.id_mem_read = 1; s.id_reg_write = 1; s.id_rd = 4; s.id_rs = 1; s.id_alu_op = 3'b010;
    step(s);
    s = idle;
    s.id_valid = 1; s.id_rs = 4; s.id_rt = 5; s.id_rd = 6; s.id_rs_val = 32'h44; s.id_rt_val = 32'h55;
    s.id_reg_write = 1; s.id_alu_op = 3'b010;
    step(s);
    @(negedge clk); #1;
    chk("lu_stall", load_use_stall, 1'b1);
    step(s);
    @(negedge clk); #1;
    chk("lu_bubble_valid", ex_valid, 1'b0);
    chk("lu_bubble_op", alu_op, 3'b010);
    chk("lu_no_stall", load_use_stall, 1'b0);
    t = idle;
    t.mwb_reg_write = 1; t.mwb_rd = 4; t.mwb_result = 32'h4040;
    step(t);
    @(negedge clk); #1;
    chk("lu_capture_valid", ex_valid, 1'b1);
    chk("lu_capture_a", alu_a, 32'h4040);
    chk("lu_capture_b", alu_b, 32'h55);

    // Flush wins over stall.
    s = idle;
    s.id_valid = 1; s.id_rs = 2; s.id_reg_write = 1; s.id_rd = 2; s.stall = 1; s.flush = 1;
    step(s);
    t = idle;
    t.stall = 1;
    step(t);
    @(negedge clk); #1;
    chk("flush_stall_valid", ex_valid, 1'b0);
    chk("flush_stall_rw", ex_reg_write, 1'b0);

    // Stall alone holds every output for three cycles.
    s = idle;
    s.id_valid = 1; s.id_rs = 6; s.id_rt = 7; s.id_rd = 8;
    s.id_rs_val = 32'h1234; s.id_rt_val = 32'h5678; s.id_alu_op = 3'b110; s.id_reg_write = 1;
    step(s);
    for (int i = 0; i < 3; i++) begin
      t = rnd();
      t.stall = 1; t.flush = 0; t.exm_reg_write = 0; t.mwb_reg_write = 0;
      step(t);
      @(negedge clk); #1;
      chk("stall_a", alu_a, 32'h1234);
      chk("stall_b", alu_b, 32'h5678);
      chk("stall_op", alu_op, 3'b110);
      chk("stall_valid", ex_valid, 1'b1);
      chk("stall_rd", ex_rd, 5'd8);
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      step(rnd());
    end
    step(idle);
    @(negedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
